// File: rtl/vnu_pkg.sv
// Shared types and helpers for the serial variable-node accumulator.
package vnu_pkg;

    localparam int DW  = 6;
    localparam int DEG = 3;
    localparam int SW  = DW + $clog2(DEG + 1) + 1;

    typedef logic [DW-1:0]        msg_sm_t;
    typedef logic signed [SW-1:0] acc_t;

    typedef enum logic {
        S_COLLECT = 1'b0,
        S_EMIT    = 1'b1
    } state_t;

    // Sign-magnitude to sign-extended two's complement; negative zero maps to 0.
    function automatic acc_t sm2tc(input msg_sm_t m);
        acc_t mag;
        mag           = '0;
        mag[DW-2:0]   = m[DW-2:0];
        return m[DW-1] ? -mag : mag;
    endfunction

endpackage

// File: rtl/vnu_tc2sm_sat.sv
// Two's complement (SW bits) to saturated sign-magnitude (DW bits).
// Zero always encodes as all-zero, so negative zero never leaves the block.
module vnu_tc2sm_sat #(
    parameter int DW = 6,
    parameter int SW = 9
) (
    input  logic [SW-1:0] x_i,
    output logic [DW-1:0] sm_o
);

    localparam logic [SW-1:0] MAXM = SW'((1 << (DW - 1)) - 1);
    localparam logic [SW-1:0] ONE  = SW'(1);

    logic          neg;
    logic [SW-1:0] mag;

    // Absolute value, then clamp to the largest representable magnitude.
    always_comb begin
        neg  = x_i[SW-1];
        mag  = neg ? (~x_i + ONE) : x_i;
        sm_o = {neg, (mag > MAXM) ? MAXM[DW-2:0] : mag[DW-2:0]};
    end

endmodule

// File: rtl/vnu_serial_accum.sv
// Serial VNU: collects DEG check messages plus the channel LLR, then streams
// DEG extrinsic messages (total minus own input) and a hard decision.
module vnu_serial_accum
    import vnu_pkg::*;
#(
    parameter int DW  = vnu_pkg::DW,
    parameter int DEG = vnu_pkg::DEG
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [DW-1:0] i_llr,
    input  logic          i_valid,
    output logic          i_ready,
    input  logic [DW-1:0] i_data,
    output logic          o_valid,
    input  logic          o_ready,
    output logic [DW-1:0] o_data,
    output logic          o_last,
    output logic          o_hard
);

    localparam int SW = DW + $clog2(DEG + 1) + 1;
    localparam int CW = (DEG > 1) ? $clog2(DEG) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEG - 1);
    localparam logic [CW-1:0] CONE = CW'(1);

    state_t               state_q;
    logic [CW-1:0]        cnt_q;
    logic signed [SW-1:0] acc_q;
    logic signed [SW-1:0] msg_q [DEG];

    logic signed [SW-1:0] conv_d;
    logic signed [SW-1:0] base_d;
    logic signed [SW-1:0] acc_d;
    logic signed [SW-1:0] ext_d;
    logic [DW-1:0]        sm_d;
    logic                 emit;

    assign emit   = (state_q == S_EMIT);
    assign conv_d = sm2tc(i_data);
    // Beat 0 seeds the sum with the channel LLR; later beats keep adding.
    assign base_d = (cnt_q == '0) ? sm2tc(i_llr) : acc_q;
    assign acc_d  = base_d + conv_d;
    assign ext_d  = acc_q - msg_q[cnt_q];

    vnu_tc2sm_sat #(
        .DW(DW),
        .SW(SW)
    ) u_sat (
        .x_i (ext_d),
        .sm_o(sm_d)
    );

    // Outputs come only from registered state; idle outputs are forced to 0.
    assign i_ready = ~emit;
    assign o_valid = emit;
    assign o_data  = emit ? sm_d : '0;
    assign o_last  = emit & (cnt_q == LAST);
    assign o_hard  = emit & acc_q[SW-1];

    // Collect/emit FSM with counter, accumulator and per-message buffer.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= S_COLLECT;
            cnt_q   <= '0;
            acc_q   <= '0;
            for (int k = 0; k < DEG; k++) msg_q[k] <= '0;
        end else begin
            case (state_q)
                S_COLLECT: begin
                    if (i_valid) begin
                        msg_q[cnt_q] <= conv_d;
                        acc_q        <= acc_d;
                        if (cnt_q == LAST) begin
                            cnt_q   <= '0;
                            state_q <= S_EMIT;
                        end else begin
                            cnt_q <= cnt_q + CONE;
                        end
                    end
                end
                S_EMIT: begin
                    if (o_ready) begin
                        if (cnt_q == LAST) begin
                            cnt_q   <= '0;
                            acc_q   <= '0;
                            state_q <= S_COLLECT;
                        end else begin
                            cnt_q <= cnt_q + CONE;
                        end
                    end
                end
                default: state_q <= S_COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_vnu_serial_accum.sv
// Self-checking bench for vnu_serial_accum (DW=6, DEG=3).
module tb_vnu_serial_accum;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic [5:0] i_llr;
    logic       i_valid;
    logic       i_ready;
    logic [5:0] i_data;
    logic       o_valid;
    logic       o_ready;
    logic [5:0] o_data;
    logic       o_last;
    logic       o_hard;

    vnu_serial_accum dut (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_llr  (i_llr),
        .i_valid(i_valid),
        .i_ready(i_ready),
        .i_data (i_data),
        .o_valid(o_valid),
        .o_ready(o_ready),
        .o_data (o_data),
        .o_last (o_last),
        .o_hard (o_hard)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [5:0] d;
        logic       l;
        logic       h;
    } exp_t;

    typedef struct {
        logic [5:0] llr;
        logic [5:0] m0, m1, m2;
        logic [5:0] e0, e1, e2;
        logic       hard;
    } vec_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   got   = 0;
    bit   accepted;

    task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", n, a, e, $time);
        end
    endtask

    // Reference model, written from the message/saturation definitions.
    function automatic int conv(input logic [5:0] s);
        int m;
        m = int'(s[4:0]);
        return s[5] ? -m : m;
    endfunction

    function automatic logic [5:0] sat(input int x);
        int m;
        m = (x < 0) ? -x : x;
        if (m > 31) m = 31;
        return {(x < 0) ? 1'b1 : 1'b0, m[4:0]};
    endfunction

    task automatic push_model(input logic [5:0] llr, m0, m1, m2);
        logic [5:0] m [3];
        int t;
        exp_t e;
        m[0] = m0; m[1] = m1; m[2] = m2;
        t = conv(llr) + conv(m0) + conv(m1) + conv(m2);
        for (int k = 0; k < 3; k++) begin
            e.d = sat(t - conv(m[k]));
            e.l = (k == 2);
            e.h = (t < 0);
            sb.push_back(e);
        end
    endtask

    task automatic push_vec(input vec_t v);
        exp_t e;
        e.h = v.hard;
        e.d = v.e0; e.l = 1'b0; sb.push_back(e);
        e.d = v.e1; e.l = 1'b0; sb.push_back(e);
        e.d = v.e2; e.l = 1'b1; sb.push_back(e);
    endtask

    // Entered at a negedge with inputs set; checks the handshake due at the
    // next posedge, then returns at the following negedge.
    task automatic step();
        exp_t e;
        #1;
        accepted = i_valid && i_ready;
        if (o_valid && o_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", {2'b0, o_data}, 8'hff);
            end else begin
                e = sb.pop_front();
                chk("o_data", {2'b0, o_data}, {2'b0, e.d});
                chk("o_last", {7'b0, o_last}, {7'b0, e.l});
                chk("o_hard", {7'b0, o_hard}, {7'b0, e.h});
            end
            got++;
        end
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic beat(input logic [5:0] llr, input logic [5:0] d);
        int tries;
        i_valid = 1'b1;
        i_data  = d;
        i_llr   = llr;
        tries   = 0;
        do begin
            step();
            tries++;
        end while (!accepted && tries < 20);
        if (!accepted) chk("beat_timeout", 8'd0, 8'd1);
        i_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            i_valid = 1'b0;
            i_data  = 6'($urandom);
            i_llr   = 6'($urandom);
            step();
        end
    endtask

    // Full input burst; llr is driven only on beat 0, garbage afterwards.
    task automatic send_burst(input logic [5:0] llr, m0, m1, m2, input int g1, g2);
        beat(llr, m0);
        idle(g1);
        beat(6'($urandom), m1);
        idle(g2);
        beat(6'($urandom), m2);
        #1;
        chk("lat_o_valid", {7'b0, o_valid}, 8'd1);
        chk("emit_i_ready", {7'b0, i_ready}, 8'd0);
    endtask

    task automatic drain(input int n, input bit stall, input bit fin);
        int g0, cyc;
        logic [5:0] d0;
        logic       l0, h0;
        g0  = got;
        cyc = 0;
        while (got - g0 < n && cyc < 200) begin
            if (stall) begin
                o_ready = 1'b0;
                #1;
                d0 = o_data; l0 = o_last; h0 = o_hard;
                for (int s = 0; s < 3; s++) begin
                    step();
                    #1;
                    chk("stall_data", {2'b0, o_data}, {2'b0, d0});
                    chk("stall_last", {7'b0, o_last}, {7'b0, l0});
                    chk("stall_hard", {7'b0, o_hard}, {7'b0, h0});
                    chk("stall_i_ready", {7'b0, i_ready}, 8'd0);
                end
            end
            o_ready = 1'b1;
            step();
            cyc++;
        end
        if (got - g0 < n) chk("drain_timeout", 8'(got - g0), 8'(n));
        if (fin) begin
            #1;
            chk("post_o_valid", {7'b0, o_valid}, 8'd0);
            chk("post_i_ready", {7'b0, i_ready}, 8'd1);
            chk("sb_empty", 8'(sb.size()), 8'd0);
        end
    endtask

    task automatic do_reset();
        i_valid = 1'b0;
        o_ready = 1'b0;
        i_rst_n = 1'b0;
        step();
        i_rst_n = 1'b1;
        sb.delete();
        #1;
        chk("rst_o_valid", {7'b0, o_valid}, 8'd0);
        chk("rst_i_ready", {7'b0, i_ready}, 8'd1);
    endtask

    vec_t tbl [4];
    vec_t nom;

    initial begin
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_llr   = '0;
        i_data  = '0;
        o_ready = 1'b1;

        //        llr        m0         m1         m2         e0         e1         e2         hard
        tbl[0] = '{6'b000101, 6'b000011, 6'b100010, 6'b001010, 6'b001101, 6'b010010, 6'b000110, 1'b0};
        tbl[1] = '{6'b011111, 6'b011111, 6'b011111, 6'b011111, 6'b011111, 6'b011111, 6'b011111, 1'b0};
        tbl[2] = '{6'b110100, 6'b100001, 6'b100001, 6'b100000, 6'b110101, 6'b110101, 6'b110110, 1'b1};
        tbl[3] = '{6'b100000, 6'b100000, 6'b100000, 6'b100000, 6'b000000, 6'b000000, 6'b000000, 1'b0};
        nom = tbl[0];

        repeat (2) @(negedge i_clk);
        #1;
        chk("reset_i_ready", {7'b0, i_ready}, 8'd1);
        chk("reset_o_valid", {7'b0, o_valid}, 8'd0);
        chk("reset_o_data", {2'b0, o_data}, 8'd0);
        chk("reset_o_last", {7'b0, o_last}, 8'd0);
        chk("reset_o_hard", {7'b0, o_hard}, 8'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Table of directed bursts.
        for (int v = 0; v < 4; v++) begin
            push_vec(tbl[v]);
            send_burst(tbl[v].llr, tbl[v].m0, tbl[v].m1, tbl[v].m2, 0, 0);
            drain(3, 1'b0, 1'b1);
        end

        // Backpressure: 3 stalled cycles ahead of every output.
        push_vec(nom);
        send_burst(nom.llr, nom.m0, nom.m1, nom.m2, 0, 0);
        drain(3, 1'b1, 1'b1);

        // Input gaps: valid pattern 1,0,0,1,0,1 with garbage llr off beat 0.
        push_vec(nom);
        send_burst(nom.llr, nom.m0, nom.m1, nom.m2, 2, 1);
        drain(3, 1'b0, 1'b1);

        // Reset after two accepted inputs, then a clean burst.
        beat(nom.llr, nom.m0);
        beat(6'($urandom), nom.m1);
        do_reset();
        push_vec(nom);
        send_burst(nom.llr, nom.m0, nom.m1, nom.m2, 0, 0);
        drain(3, 1'b0, 1'b1);

        // Reset after one output, then a clean burst.
        push_vec(nom);
        send_burst(nom.llr, nom.m0, nom.m1, nom.m2, 0, 0);
        drain(1, 1'b0, 1'b0);
        do_reset();
        push_vec(nom);
        send_burst(nom.llr, nom.m0, nom.m1, nom.m2, 0, 0);
        drain(3, 1'b0, 1'b1);

        // Random bursts against the model.
        for (int r = 0; r < 6; r++) begin
            logic [5:0] l, a, b, c;
            l = 6'($urandom); a = 6'($urandom); b = 6'($urandom); c = 6'($urandom);
            push_model(l, a, b, c);
            send_burst(l, a, b, c, $urandom_range(0, 2), $urandom_range(0, 2));
            drain(3, 1'($urandom_range(0, 1)), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vnu_serial_accum.md
Name: vnu_serial_accum

Overview:
- Serial variable-node accumulator for the shuffled GLDPC VNU.
- Consumes a burst of DEG check-to-variable messages in 6-bit sign-magnitude, plus the channel LLR.
- Converts each message to two's complement and accumulates the total posterior.
- Streams back DEG extrinsic variable-to-check messages (total minus own input), saturated and re-encoded to sign-magnitude, plus a hard decision.

Parameters:
- DW, 6, message/LLR width in sign-magnitude (MSB = sign, DW-1 magnitude bits).
- DEG, 3, messages per variable node per burst (>=2).
- SW, DW+$clog2(DEG+1)+1 (localparam), signed accumulator width; never overflows.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  synchronous active-low reset.
- i_llr  in  DW  channel LLR, sign-magnitude; sampled with the first accepted message of a burst.
- i_valid  in  1  input message valid.
- i_ready  out  1  block can accept a message.
- i_data  in  DW  check-to-variable message, sign-magnitude.
- o_valid  out  1  extrinsic message valid.
- o_ready  in  1  downstream accepts.
- o_data  out  DW  extrinsic message, sign-magnitude, saturated.
- o_last  out  1  marks the DEG-th output of a burst.
- o_hard  out  1  hard decision (1 = total < 0); stable while o_valid during a burst.

Behaviour:
- Clock and reset: one clock, i_clk. Reset is synchronous, active-low on i_rst_n.
- Reset values:
  - FSM in S_COLLECT; counter 0; accumulator 0.
  - i_ready = 1; o_valid = 0; o_data = 0; o_last = 0; o_hard = 0.
- SM to two's complement conversion:
  - Value = sign ? -mag : +mag.
  - Negative zero (sign=1, mag=0) = 0.
  - Sign-extend to SW.
- S_COLLECT:
  - i_ready = 1. A beat is accepted on i_valid & i_ready.
  - Beat 0: acc <= conv(i_llr) + conv(i_data).
  - Beats 1..DEG-1: acc <= acc + conv(i_data).
  - Each converted message is stored in buffer msg[cnt]; cnt increments per beat.
  - On acceptance of beat DEG-1: next cycle enter S_EMIT, cnt <= 0, i_ready = 0.
  - i_llr is ignored on beats other than 0.
- S_EMIT:
  - o_valid = 1. o_data = sat_sm(acc - msg[cnt]). o_last = (cnt == DEG-1). o_hard = acc[SW-1].
  - Latency: first o_valid asserts 1 cycle after the last input beat is accepted.
  - On o_valid & o_ready: cnt increments.
  - While o_ready = 0: o_data, o_last and o_hard hold; no state change.
  - After the last handshake (o_last & o_ready): the next cycle is S_COLLECT with i_ready = 1, o_valid = 0, cnt = 0, acc = 0.
  - No input is accepted during S_EMIT; bursts do not overlap.
- sat_sm(x):
  - Magnitude = min(|x|, 2^(DW-1)-1); sign = (x < 0).
  - x = 0 gives all-zero output; negative zero is never emitted.
- Outputs o_data/o_last/o_hard are driven from registered state (acc, msg buffer, cnt) through sat_sm. No combinational path exists from i_* to o_*.
- Reset mid-burst, in either state:
  - The partial burst is discarded and all state returns to reset values on the next edge.
  - The first beat after reset is treated as beat 0.
- i_valid may drop between beats; the accumulation simply pauses.

Decomposition:
- Package vnu_pkg holds:
  - DW and DEG defaults;
  - msg_sm_t (logic [DW-1:0]);
  - acc_t (logic signed [SW-1:0]);
  - state enum {S_COLLECT, S_EMIT};
  - function sm2tc (sign-magnitude to two's complement, negative zero gives 0).
- One sub-module: vnu_tc2sm_sat, a combinational SW-bit two's complement to DW-bit saturated sign-magnitude converter, instantiated once on the output path.

Test Plan:
- Nominal burst, DEG=3:
  - Stimulus: llr=000101 (+5); msgs 000011 (+3), 100010 (-2), 001010 (+10).
  - Required: total 16; outputs 001101, 010010, 000110; o_last on the third output only; o_hard=0.
  - Required: first o_valid exactly 1 cycle after the third input handshake.
- Saturation:
  - Stimulus: llr=011111; msgs 011111 x3 (total 124).
  - Required: every output 011111 (93 saturated to 31).
- Negative path and negative zero:
  - Stimulus: llr=110100 (-20); msgs 100001, 100001, 100000.
  - Required: total -22; outputs 110101, 110101, 110110; o_hard=1.
  - Stimulus: all inputs 100000.
  - Required: outputs 000000; o_hard=0.
- Backpressure:
  - Stimulus: during S_EMIT, hold o_ready=0 for 3 cycles before each output.
  - Required: o_data/o_last stable while stalled; exactly DEG handshakes; i_ready stays 0 until the cycle after the last handshake.
- Input gaps:
  - Stimulus: i_valid toggles 1,0,0,1,0,1.
  - Required: results identical to the nominal burst; i_llr changes on beats 1..2 have no effect.
- Reset mid-operation:
  - Stimulus: assert i_rst_n=0 for 1 cycle after 2 inputs accepted, and separately after 1 output.
  - Required: o_valid=0 and i_ready=1 on the next cycle; a following clean burst produces the nominal results.
